// File: rtl/depthwise_acc_requant.sv
// Depthwise tap accumulator with bias, round-half-up requantization, optional ReLU
// and saturation, presented on a valid/ready output register.
module depthwise_acc_requant #(
    parameter int unsigned KERNEL_TAPS = 9,
    parameter int unsigned IN_W        = 18,
    parameter int unsigned BIAS_W      = 18,
    parameter int unsigned ACC_W       = 22,
    parameter int unsigned SHIFT       = 4,
    parameter int unsigned OUT_W       = 8,
    parameter int unsigned RELU        = 0
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clr,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [IN_W-1:0]            in_data,
    input  logic signed [BIAS_W-1:0]          bias,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [OUT_W-1:0]           out_data,
    output logic                              out_sat,
    output logic [$clog2(KERNEL_TAPS)-1:0]    tap_idx
);

    localparam int unsigned TAP_W = $clog2(KERNEL_TAPS);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERNEL_TAPS - 1);
    localparam logic signed [ACC_W:0] ROUND =
        (SHIFT > 0) ? ((ACC_W+1)'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_W:0] OUT_MAX =
        {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

    logic [TAP_W-1:0]        tap_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] first_sum;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W:0]   rounded;
    logic signed [ACC_W:0]   relu_val;
    logic signed [OUT_W-1:0] sat_val;
    logic                    sat_flag;
    logic                    is_last;
    logic                    xfer;
    logic                    load;

    assign is_last  = (tap_cnt == LAST_TAP);
    assign in_ready = !is_last || !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    assign load     = xfer && is_last && !clr;
    assign tap_idx  = tap_cnt;

    always_comb begin
        in_ext    = ACC_W'(in_data);
        bias_ext  = ACC_W'(bias);
        first_sum = bias_ext + in_ext;
        sum       = acc + in_ext;
        // One extra bit so the rounding increment cannot overflow the sum.
        rounded   = ((ACC_W+1)'(sum) + ROUND) >>> SHIFT;
        relu_val  = rounded;
        if (RELU != 0 && rounded < 0) begin
            relu_val = '0;
        end
        sat_val  = relu_val[OUT_W-1:0];
        sat_flag = 1'b0;
        if (relu_val > OUT_MAX) begin
            sat_val  = OUT_MAX[OUT_W-1:0];
            sat_flag = 1'b1;
        end else if (relu_val < OUT_MIN) begin
            sat_val  = OUT_MIN[OUT_W-1:0];
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap_cnt <= '0;
            acc     <= '0;
        end else if (clr) begin
            tap_cnt <= '0;
            acc     <= '0;
        end else if (xfer) begin
            acc     <= (tap_cnt == '0) ? first_sum : sum;
            tap_cnt <= is_last ? '0 : tap_cnt + 1'b1;
        end
    end

    // A drain and a new load in the same cycle keep the register full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sat_val;
            out_sat   <= sat_flag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_depthwise_acc_requant.sv
// Randomized and directed bench for depthwise_acc_requant against a plain-arithmetic
// reference model; a RELU=1 copy runs on the same stimulus.
module tb_depthwise_acc_requant;

    localparam int K     = 9;
    localparam int IN_W  = 18;
    localparam int SHIFT = 4;
    localparam int OUT_W = 8;

    typedef struct {
        longint data;
        bit     sat;
        longint rdata;
        bit     rsat;
    } result_t;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    clr = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [IN_W-1:0]  in_data = '0;
    logic signed [17:0]      bias = '0;
    logic                    out_ready = 1'b0;
    logic                    in_ready, in_ready_r;
    logic                    out_valid, out_valid_r;
    logic signed [OUT_W-1:0] out_data, out_data_r;
    logic                    out_sat, out_sat_r;
    logic [3:0]              tap_idx, tap_idx_r;

    int num_checks = 0;
    int num_fails  = 0;

    result_t m_q[$];
    int      m_taps = 0;
    longint  m_acc  = 0;
    int      m_loads = 0;
    bit      seen_ready;

    depthwise_acc_requant #(.KERNEL_TAPS(K), .IN_W(IN_W), .BIAS_W(18), .ACC_W(22),
                            .SHIFT(SHIFT), .OUT_W(OUT_W), .RELU(0)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .tap_idx(tap_idx));

    depthwise_acc_requant #(.KERNEL_TAPS(K), .IN_W(IN_W), .BIAS_W(18), .ACC_W(22),
                            .SHIFT(SHIFT), .OUT_W(OUT_W), .RELU(1)) dut_relu (
        .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_data(in_data), .bias(bias), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .out_sat(out_sat_r), .tap_idx(tap_idx_r));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void requant(input longint s, input bit relu,
                                    output longint r, output bit sat);
        longint half;
        longint hi, lo;
        half = (SHIFT > 0) ? (longint'(1) <<< (SHIFT - 1)) : 0;
        r    = (s + half) >>> SHIFT;
        if (relu && r < 0) r = 0;
        hi  = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo  = -(longint'(1) <<< (OUT_W - 1));
        sat = 1'b0;
        if (r > hi) begin r = hi; sat = 1'b1; end
        if (r < lo) begin r = lo; sat = 1'b1; end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_taps = 0;
        m_acc  = 0;
    endfunction

    // One clock: drive at negedge, predict, then compare just after the posedge.
    task automatic cycle(input bit v, input longint d, input longint b,
                         input bit ordy, input bit c);
        bit      exp_ready;
        result_t res;
        @(negedge clk);
        in_valid  = v;
        in_data   = IN_W'(d);
        bias      = 18'(b);
        out_ready = ordy;
        clr       = c;
        #1;
        exp_ready  = !(m_taps == K - 1 && m_q.size() != 0 && !ordy);
        seen_ready = in_ready;
        check_eq("in_ready", longint'(in_ready), longint'(exp_ready));
        check_eq("in_ready_relu", longint'(in_ready_r), longint'(exp_ready));
        if (m_q.size() != 0 && ordy) void'(m_q.pop_front());
        if (c) begin
            m_taps = 0;
            m_acc  = 0;
        end else if (v && exp_ready) begin
            if (m_taps == 0) m_acc = longint'(bias) + longint'(in_data);
            else             m_acc = m_acc + longint'(in_data);
            m_taps++;
            if (m_taps == K) begin
                requant(m_acc, 1'b0, res.data, res.sat);
                requant(m_acc, 1'b1, res.rdata, res.rsat);
                m_q.push_back(res);
                m_taps = 0;
                m_loads++;
            end
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", longint'(out_valid), longint'(m_q.size() != 0));
        check_eq("out_valid_relu", longint'(out_valid_r), longint'(m_q.size() != 0));
        check_eq("tap_idx", longint'(tap_idx), longint'(m_taps));
        if (m_q.size() != 0) begin
            check_eq("out_data", longint'(out_data), m_q[0].data);
            check_eq("out_sat", longint'(out_sat), longint'(m_q[0].sat));
            check_eq("out_data_relu", longint'(out_data_r), m_q[0].rdata);
            check_eq("out_sat_relu", longint'(out_sat_r), longint'(m_q[0].rsat));
        end
    endtask

    // Full window with the output drained freely; checks the result against constants.
    task automatic window(input string tag, input longint b, input longint d,
                          input longint ed, input bit es, input longint erd, input bit ers);
        for (int i = 0; i < K; i++) cycle(1'b1, d, (i == 0) ? b : 0, 1'b1, 1'b0);
        check_eq({tag, "_valid"}, longint'(out_valid), 1);
        check_eq({tag, "_data"}, longint'(out_data), ed);
        check_eq({tag, "_sat"}, longint'(out_sat), longint'(es));
        check_eq({tag, "_rdata"}, longint'(out_data_r), erd);
        check_eq({tag, "_rsat"}, longint'(out_sat_r), longint'(ers));
        cycle(1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        int cycles;
        #12;
        check_eq("rst_out_valid", longint'(out_valid), 0);
        check_eq("rst_out_data", longint'(out_data), 0);
        check_eq("rst_out_sat", longint'(out_sat), 0);
        check_eq("rst_tap_idx", longint'(tap_idx), 0);
        check_eq("rst_in_ready", longint'(in_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        window("basic", 0, 16, 9, 0, 9, 0);
        window("sat_pos", 0, 20000, 127, 1, 127, 1);
        window("sat_neg", 0, -20000, -128, 1, 0, 0);
        window("sum_m24", -24, 0, -1, 0, 0, 0);
        window("sum_m8", -8, 0, 0, 0, 0, 0);
        window("bias_m100", -100, 0, -6, 0, 0, 0);

        // Backpressure: hold a result, next window stalls only on the last tap.
        for (int i = 0; i < K; i++) cycle(1'b1, 16, 0, 1'b0, 1'b0);
        for (int i = 0; i < K - 1; i++) cycle(1'b1, 32, (i == 0) ? 0 : 5, 1'b0, 1'b0);
        cycle(1'b1, 32, 0, 1'b0, 1'b0);
        check_eq("bp_stall", longint'(seen_ready), 0);
        check_eq("bp_held", longint'(out_data), 9);
        cycle(1'b1, 32, 0, 1'b1, 1'b0);
        check_eq("bp_accept", longint'(seen_ready), 1);
        check_eq("bp_new", longint'(out_data), 18);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Abort a partial window; the discarded tap must not count.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1000, 0, 1'b1, 1'b0);
        cycle(1'b1, 1000, 0, 1'b1, 1'b1);
        check_eq("clr_tap_idx", longint'(tap_idx), 0);
        window("after_clr", 0, 16, 9, 0, 9, 0);

        // Random windows with random gaps, backpressure and the odd clear.
        m_loads = 0;
        cycles  = 0;
        while (m_loads < 20 && cycles < 5000) begin
            cycle($urandom_range(0, 3) != 0, longint'(signed'(IN_W'($urandom))),
                  longint'(signed'(18'($urandom))), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 59) == 0);
            cycles++;
        end
        check_eq("rand_windows", m_loads >= 20, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Asynchronous reset mid-window while a result is held.
        for (int i = 0; i < K; i++) cycle(1'b1, 16, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 16, 0, 1'b0, 1'b0);
        check_eq("pre_rst_valid", longint'(out_valid), 1);
        check_eq("pre_rst_tap", longint'(tap_idx), 4);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_out_valid", longint'(out_valid), 0);
        check_eq("arst_out_data", longint'(out_data), 0);
        check_eq("arst_tap_idx", longint'(tap_idx), 0);
        check_eq("arst_relu_valid", longint'(out_valid_r), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        window("after_rst", 0, 16, 9, 0, 9, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
